// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters with registered sync, blanking,
// pixel coordinates, frame-start strobe and completed-frame counter.
module vga_timing_gen #(
    parameter int   H_VISIBLE = 640,
    parameter int   H_FRONT   = 16,
    parameter int   H_SYNC    = 96,
    parameter int   H_BACK    = 48,
    parameter int   V_VISIBLE = 480,
    parameter int   V_FRONT   = 10,
    parameter int   V_SYNC    = 2,
    parameter int   V_BACK    = 33,
    parameter logic SYNC_POL  = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    output logic       hsync,
    output logic       vsync,
    output logic       video_active,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_start,
    output logic [9:0] frame_count
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS  = 11'(H_VISIBLE);
    localparam logic [10:0] V_VIS  = 11'(V_VISIBLE);
    localparam logic [10:0] HS_BEG = 11'(H_VISIBLE + H_FRONT);
    localparam logic [10:0] HS_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_BEG = 11'(V_VISIBLE + V_FRONT);
    localparam logic [10:0] VS_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [9:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [9:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [9:0] frame_count_q, frame_count_d;
    logic       hsync_q, hsync_d, vsync_q, vsync_d;
    logic       video_active_q, video_active_d;
    logic       frame_start_q, frame_start_d;
    logic       started_q, started_d;
    logic       at_origin;
    logic [10:0] h_ext, v_ext;

    assign h_ext     = {1'b0, h_cnt_q};
    assign v_ext     = {1'b0, v_cnt_q};
    assign at_origin = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);

    always_comb begin
        h_cnt_d        = h_cnt_q;
        v_cnt_d        = v_cnt_q;
        pix_x_d        = pix_x_q;
        pix_y_d        = pix_y_q;
        hsync_d        = hsync_q;
        vsync_d        = vsync_q;
        video_active_d = video_active_q;
        frame_count_d  = frame_count_q;
        started_d      = started_q;
        frame_start_d  = 1'b0;
        if (ena) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = 10'd0;
                v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
            // Outputs present the pre-increment count so every output describes the same pixel.
            pix_x_d        = h_cnt_q;
            pix_y_d        = v_cnt_q;
            video_active_d = (h_ext < H_VIS) && (v_ext < V_VIS);
            hsync_d        = ((h_ext >= HS_BEG) && (h_ext < HS_END)) ? SYNC_POL : ~SYNC_POL;
            vsync_d        = ((v_ext >= VS_BEG) && (v_ext < VS_END)) ? SYNC_POL : ~SYNC_POL;
            frame_start_d  = at_origin;
            started_d      = 1'b1;
            // The first origin after reset opens frame 0; later origins close a frame.
            if (at_origin && started_q)
                frame_count_d = frame_count_q + 10'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q        <= 10'd0;
            v_cnt_q        <= 10'd0;
            pix_x_q        <= 10'd0;
            pix_y_q        <= 10'd0;
            hsync_q        <= ~SYNC_POL;
            vsync_q        <= ~SYNC_POL;
            video_active_q <= 1'b0;
            frame_start_q  <= 1'b0;
            frame_count_q  <= 10'd0;
            started_q      <= 1'b0;
        end else begin
            h_cnt_q        <= h_cnt_d;
            v_cnt_q        <= v_cnt_d;
            pix_x_q        <= pix_x_d;
            pix_y_q        <= pix_y_d;
            hsync_q        <= hsync_d;
            vsync_q        <= vsync_d;
            video_active_q <= video_active_d;
            frame_start_q  <= frame_start_d;
            frame_count_q  <= frame_count_d;
            started_q      <= started_d;
        end
    end

    assign hsync        = hsync_q;
    assign vsync        = vsync_q;
    assign video_active = video_active_q;
    assign pix_x        = pix_x_q;
    assign pix_y        = pix_y_q;
    assign frame_start  = frame_start_q;
    assign frame_count  = frame_count_q;
endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: default 640x480 instance for line-level timing, tiny
// active-high-sync instance (8x7 raster) for frame, hold and counter-wrap behaviour.
module tb_vga_timing_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       d_rst_n, d_ena, d_hs, d_vs, d_va, d_fs;
    logic [9:0] d_x, d_y, d_fc;
    logic       s_rst_n, s_ena, s_hs, s_vs, s_va, s_fs;
    logic [9:0] s_x, s_y, s_fc;

    int tests = 0;
    int fails = 0;

    vga_timing_gen u_def (
        .clk(clk), .rst_n(d_rst_n), .ena(d_ena), .hsync(d_hs), .vsync(d_vs),
        .video_active(d_va), .pix_x(d_x), .pix_y(d_y), .frame_start(d_fs), .frame_count(d_fc)
    );

    // Small raster: H 4+1+2+1=8 (hsync x=5..6), V 3+1+2+1=7 (vsync y=4..5), 56 cycles/frame.
    vga_timing_gen #(
        .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
        .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(2), .V_BACK(1), .SYNC_POL(1'b1)
    ) u_small (
        .clk(clk), .rst_n(s_rst_n), .ena(s_ena), .hsync(s_hs), .vsync(s_vs),
        .video_active(s_va), .pix_x(s_x), .pix_y(s_y), .frame_start(s_fs), .frame_count(s_fc)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        d_rst_n = 1'b0; d_ena = 1'b0; s_rst_n = 1'b0; s_ena = 1'b0;
        tick(); tick();
        tests++;
        if ({d_x, d_y, d_va, d_hs, d_vs, d_fs, d_fc} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b1, 1'b0, 10'd0}) begin
            fails++; $display("FAIL reset_def: got x=%0d y=%0d va=%b hs=%b vs=%b fs=%b fc=%0d want 0 0 0 1 1 0 0",
                              d_x, d_y, d_va, d_hs, d_vs, d_fs, d_fc);
        end
        tests++;
        if ({s_hs, s_vs, s_va} !== 3'b000) begin
            fails++; $display("FAIL reset_small_pol: got hs=%b vs=%b va=%b want 000", s_hs, s_vs, s_va);
        end
        d_rst_n = 1'b1; d_ena = 1'b1;
        tick();
        tests++;
        if ({d_x, d_y, d_va, d_fs, d_fc} !== {10'd0, 10'd0, 1'b1, 1'b1, 10'd0}) begin
            fails++; $display("FAIL first_pixel: got x=%0d y=%0d va=%b fs=%b fc=%0d want 0 0 1 1 0",
                              d_x, d_y, d_va, d_fs, d_fc);
        end
    endtask

    task automatic test_line();
        int mism = 0, hs_low = 0, hs_first = -1, va_fall = -1, ex, ey;
        logic pva;
        pva = d_va;
        for (int k = 1; k <= 800; k++) begin
            tick();
            ex = k % 800; ey = k / 800;
            if (d_x !== 10'(ex) || d_y !== 10'(ey) || d_va !== (ex < 640 && ey < 480) ||
                d_hs !== !(ex >= 656 && ex < 752) || d_vs !== 1'b1 || d_fs !== 1'b0) mism++;
            if (d_hs === 1'b0) begin
                hs_low++;
                if (hs_first < 0) hs_first = int'(d_x);
            end
            if (pva && !d_va && va_fall < 0) va_fall = int'(d_x);
            pva = d_va;
        end
        tests++;
        if (mism !== 0) begin fails++; $display("FAIL line_track: got %0d bad cycles want 0", mism); end
        tests++;
        if (hs_low !== 96) begin fails++; $display("FAIL hsync_width: got %0d want 96", hs_low); end
        tests++;
        if (hs_first !== 656) begin fails++; $display("FAIL hsync_start: got %0d want 656", hs_first); end
        tests++;
        if (va_fall !== 640) begin fails++; $display("FAIL va_fall_x: got %0d want 640", va_fall); end
        tests++;
        if ({d_x, d_y} !== {10'd0, 10'd1}) begin
            fails++; $display("FAIL line_wrap: got x=%0d y=%0d want 0 1", d_x, d_y);
        end
    endtask

    task automatic test_async_reset();
        for (int k = 0; k < 300; k++) tick();
        tests++;
        if ({d_x, d_y} !== {10'd300, 10'd1}) begin
            fails++; $display("FAIL pre_reset_pos: got x=%0d y=%0d want 300 1", d_x, d_y);
        end
        #2 d_rst_n = 1'b0;
        #1;
        tests++;
        if ({d_x, d_y, d_va, d_hs, d_fs} !== {10'd0, 10'd0, 1'b0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL async_reset: got x=%0d y=%0d va=%b hs=%b fs=%b want 0 0 0 1 0",
                              d_x, d_y, d_va, d_hs, d_fs);
        end
        tick();
        d_rst_n = 1'b1;
        tick(); tick();
        tests++;
        if ({d_x, d_y, d_va, d_fs} !== {10'd1, 10'd0, 1'b1, 1'b0}) begin
            fails++; $display("FAIL restart: got x=%0d y=%0d va=%b fs=%b want 1 0 1 0", d_x, d_y, d_va, d_fs);
        end
        d_ena = 1'b0;
    endtask

    task automatic test_frame();
        int mism = 0, fs_cnt = 0, vs_hi = 0, ex, ey;
        s_rst_n = 1'b1; s_ena = 1'b1;
        tick();
        for (int k = 1; k <= 112; k++) begin
            tick();
            ex = k % 8; ey = (k / 8) % 7;
            if (s_x !== 10'(ex) || s_y !== 10'(ey) || s_va !== (ex < 4 && ey < 3) ||
                s_hs !== (ex >= 5 && ex < 7) || s_vs !== (ey >= 4 && ey < 6) ||
                s_fs !== (ex == 0 && ey == 0)) mism++;
            if (s_fs === 1'b1) fs_cnt++;
            if (k <= 56 && s_vs === 1'b1) vs_hi++;
            if (k == 56) begin
                tests++;
                if (s_fc !== 10'd1) begin fails++; $display("FAIL fc_frame1: got %0d want 1", s_fc); end
            end
        end
        tests++;
        if (mism !== 0) begin fails++; $display("FAIL frame_track: got %0d bad cycles want 0", mism); end
        tests++;
        if (vs_hi !== 16) begin fails++; $display("FAIL vsync_width: got %0d want 16", vs_hi); end
        tests++;
        if (fs_cnt !== 2) begin fails++; $display("FAIL fs_count: got %0d want 2", fs_cnt); end
        tests++;
        if (s_fc !== 10'd2) begin fails++; $display("FAIL fc_frame2: got %0d want 2", s_fc); end
    endtask

    task automatic test_ena_hold();
        for (int k = 0; k < 55; k++) tick();
        tests++;
        if ({s_x, s_y} !== {10'd7, 10'd6}) begin
            fails++; $display("FAIL last_pixel: got x=%0d y=%0d want 7 6", s_x, s_y);
        end
        s_ena = 1'b0;
        tick(); tick();
        tests++;
        if ({s_x, s_y, s_fs, s_fc} !== {10'd7, 10'd6, 1'b0, 10'd2}) begin
            fails++; $display("FAIL hold: got x=%0d y=%0d fs=%b fc=%0d want 7 6 0 2", s_x, s_y, s_fs, s_fc);
        end
        s_ena = 1'b1;
        tick();
        tests++;
        if ({s_x, s_y, s_fs, s_fc, s_va} !== {10'd0, 10'd0, 1'b1, 10'd3, 1'b1}) begin
            fails++; $display("FAIL resume: got x=%0d y=%0d fs=%b fc=%0d va=%b want 0 0 1 3 1",
                              s_x, s_y, s_fs, s_fc, s_va);
        end
        s_ena = 1'b0;
        tick();
        tests++;
        if ({s_x, s_y, s_fs, s_fc} !== {10'd0, 10'd0, 1'b0, 10'd3}) begin
            fails++; $display("FAIL fs_not_stretched: got x=%0d y=%0d fs=%b fc=%0d want 0 0 0 3",
                              s_x, s_y, s_fs, s_fc);
        end
        s_ena = 1'b1;
        tick();
        tests++;
        if ({s_x, s_y, s_fs} !== {10'd1, 10'd0, 1'b0}) begin
            fails++; $display("FAIL after_hold: got x=%0d y=%0d fs=%b want 1 0 0", s_x, s_y, s_fs);
        end
    endtask

    task automatic test_fc_wrap();
        int mism = 0, fs_cnt = 0, steps;
        for (int n = 1; n <= 1022; n++) begin
            steps = (n == 1) ? 55 : 56;
            for (int k = 0; k < steps; k++) begin
                tick();
                if (s_fs === 1'b1) fs_cnt++;
            end
            if (s_fc !== 10'((3 + n) % 1024) || s_fs !== 1'b1 || s_x !== 10'd0 || s_y !== 10'd0) mism++;
            if (n == 1020) begin
                tests++;
                if (s_fc !== 10'd1023) begin fails++; $display("FAIL fc_1023: got %0d want 1023", s_fc); end
            end
            if (n == 1021) begin
                tests++;
                if ({s_fc, s_x, s_y, s_fs, s_va, s_hs, s_vs} !== {10'd0, 10'd0, 10'd0, 1'b1, 1'b1, 1'b0, 1'b0}) begin
                    fails++; $display("FAIL fc_wrap: got fc=%0d x=%0d y=%0d fs=%b va=%b hs=%b vs=%b want 0 0 0 1 1 0 0",
                                      s_fc, s_x, s_y, s_fs, s_va, s_hs, s_vs);
                end
            end
        end
        tests++;
        if (s_fc !== 10'd1) begin fails++; $display("FAIL fc_after_wrap: got %0d want 1", s_fc); end
        tests++;
        if (mism !== 0) begin fails++; $display("FAIL fc_sequence: got %0d bad frames want 0", mism); end
        tests++;
        if (fs_cnt !== 1022) begin fails++; $display("FAIL fs_per_frame: got %0d want 1022", fs_cnt); end
    endtask

    initial begin
        test_reset();
        test_line();
        test_async_reset();
        test_frame();
        test_ena_hold();
        test_fc_wrap();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
